// File: rtl/sd_evt_pkg.sv
// rtl/sd_evt_pkg.sv - shared types and helpers for the event status latch
// Contents:
//   evt_edge_t : classification of a detected transition on one bit
//   sat_inc    : saturating increment used by the per-bit event counters
package sd_evt_pkg;

  // Encoded as {fall, rise} so a packed pair of detect bits casts directly.
  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } evt_edge_t;

  // Increment by one, holding at max instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt,
                                          input logic [31:0] max);
    return (cnt >= max) ? cnt : cnt + 32'd1;
  endfunction

endpackage

// File: rtl/sd_edge_counter.sv
// rtl/sd_edge_counter.sv - one bit of edge detect, sticky status and saturating counter
// Ports:
//   clk, rst     : local clock, asynchronous active-high reset
//   armed        : high once the first post-reset sample of the level is held
//   level        : synchronised input level for this bit
//   rise_en      : a 0->1 transition is an event
//   fall_en      : a 1->0 transition is an event
//   clr          : write-1-to-clear strobe for this bit
//   status       : sticky event flag
//   status_next  : value status takes on the coming edge (feeds the irq register)
//   cnt          : saturating event count
module sd_edge_counter
  import sd_evt_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             armed,
  input  logic             level,
  input  logic             rise_en,
  input  logic             fall_en,
  input  logic             clr,
  output logic             status,
  output logic             status_next,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  logic             prev;
  evt_edge_t        edge_kind;
  logic             evt;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    edge_kind = EDGE_NONE;
    // Until armed, prev does not yet hold a real sample, so nothing counts.
    if (armed) begin
      edge_kind = evt_edge_t'({~level & prev & fall_en, level & ~prev & rise_en});
    end
    evt = (edge_kind != EDGE_NONE);

    // A new event beats a simultaneous clear.
    status_next = (status & ~clr) | evt;

    cnt_next = cnt;
    if (clr && evt) begin
      cnt_next = CNT_W'(1);
    end else if (clr) begin
      cnt_next = '0;
    end else if (evt) begin
      cnt_next = CNT_W'(sat_inc(32'(cnt), CNT_MAX));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev   <= 1'b0;
      status <= 1'b0;
      cnt    <= '0;
    end else begin
      prev   <= level;
      status <= status_next;
      cnt    <= cnt_next;
    end
  end

endmodule

// File: rtl/sd_event_status_latch.sv
// rtl/sd_event_status_latch.sv - sticky edge-event status, counters and masked interrupt
// Ports:
//   clk, rst  : local clock, asynchronous active-high reset
//   in_sync   : levels already synchronised into this domain
//   rise_en   : per-bit rising-edge event enable
//   fall_en   : per-bit falling-edge event enable
//   int_en    : per-bit interrupt enable
//   clr_we    : one-cycle clear strobe
//   clr_mask  : bits cleared when clr_we is high (write-1-to-clear)
//   cnt_sel   : selects which counter appears on cnt_out
//   status    : sticky event flags
//   irq       : registered OR of enabled status bits
//   cnt_out   : count of the selected bit, zero when cnt_sel is out of range
module sd_event_status_latch
  import sd_evt_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int CNT_W = 8,
  localparam int SEL_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_sync,
  input  logic [WIDTH-1:0] rise_en,
  input  logic [WIDTH-1:0] fall_en,
  input  logic [WIDTH-1:0] int_en,
  input  logic             clr_we,
  input  logic [WIDTH-1:0] clr_mask,
  input  logic [SEL_W-1:0] cnt_sel,
  output logic [WIDTH-1:0] status,
  output logic             irq,
  output logic [CNT_W-1:0] cnt_out
);

  logic             armed;
  logic [WIDTH-1:0] status_next;
  logic [CNT_W-1:0] cnt_arr [WIDTH];

  // The first edge after reset only captures the levels; a line already
  // high at release must not look like a rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    sd_edge_counter #(
      .CNT_W(CNT_W)
    ) u_bit (
      .clk        (clk),
      .rst        (rst),
      .armed      (armed),
      .level      (in_sync[g]),
      .rise_en    (rise_en[g]),
      .fall_en    (fall_en[g]),
      .clr        (clr_we & clr_mask[g]),
      .status     (status[g]),
      .status_next(status_next[g]),
      .cnt        (cnt_arr[g])
    );
  end

  // Built from status_next so irq rises on the same edge as status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq <= 1'b0;
    end else begin
      irq <= |(status_next & int_en);
    end
  end

  always_comb begin
    cnt_out = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (cnt_sel == SEL_W'(i)) begin
        cnt_out = cnt_arr[i];
      end
    end
  end

endmodule
